// File: rtl/serial_pkg.sv
// serial_pkg: shared constants for the serial feeder and the 101101 detector.
package serial_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;
  localparam int DATA_W_DEF = 8;
  localparam logic [5:0] DET_PATTERN = 6'b101101;
endpackage

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-in/serial-out stage with valid/ready input,
// gapless back-to-back words and a stall that freezes shifting.
module serial_bit_feeder
  import serial_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              stall,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              word_done
);
  localparam int CW = $clog2(DATA_W);
  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_sreg, w_sreg_nxt;
  logic [CW-1:0]     r_bcnt, w_bcnt_nxt;
  logic              w_run, w_last, w_xfer;
  assign w_run  = (r_state == ST_SHIFT) && !stall;
  assign w_last = r_bcnt == CW'(DATA_W - 1);
  // rst_n gating keeps s_ready low while reset is held
  assign s_ready   = rst_n && ((r_state == ST_IDLE) || (w_run && w_last));
  assign w_xfer    = s_valid && s_ready;
  assign ser_valid = w_run;
  assign ser_out   = w_run && (MSB_FIRST ? r_sreg[DATA_W-1] : r_sreg[0]);
  assign busy      = r_state == ST_SHIFT;
  assign word_done = w_run && w_last;
  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_bcnt_nxt  = r_bcnt;
    if (w_xfer) begin
      w_state_nxt = ST_SHIFT;
      w_sreg_nxt  = s_data;
      w_bcnt_nxt  = '0;
    end else if (w_run) begin
      w_state_nxt = w_last ? ST_IDLE : ST_SHIFT;
      w_sreg_nxt  = MSB_FIRST ? {r_sreg[DATA_W-2:0], 1'b0} : {1'b0, r_sreg[DATA_W-1:1]};
      w_bcnt_nxt  = w_last ? '0 : r_bcnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sreg  <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: drives an MSB-first and an LSB-first feeder with shared
// stimulus; expected bit streams are queued per word and popped by a monitor.
module tb_serial_bit_feeder;
  import serial_pkg::*;
  localparam int W = DATA_W_DEF;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] s_data = '0;
  logic s_valid = 1'b0, stall = 1'b0;
  logic rdy_m, out_m, sv_m, busy_m, done_m;
  logic rdy_l, out_l, sv_l, busy_l, done_l;
  int total = 0, bad = 0, rem = 0;
  bit q_m[$], q_l[$];

  serial_bit_feeder #(.DATA_W(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_m),
    .stall(stall), .ser_out(out_m), .ser_valid(sv_m), .busy(busy_m), .word_done(done_m));
  serial_bit_feeder #(.DATA_W(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_l),
    .stall(stall), .ser_out(out_l), .ser_valid(sv_l), .busy(busy_l), .word_done(done_l));

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check control outputs, advance the model.
  task automatic cycle(input logic v, input logic st, input logic [W-1:0] d, output bit xfer);
    bit e_ready, e_valid;
    @(negedge clk);
    s_valid = v;
    stall = st;
    s_data = d;
    #1;
    e_valid = rem > 0 && !st;
    e_ready = rem == 0 || (rem == 1 && !st);
    chk("ready_m", rdy_m, e_ready);
    chk("ready_l", rdy_l, e_ready);
    chk("valid_m", sv_m, e_valid);
    chk("valid_l", sv_l, e_valid);
    chk("busy_m", busy_m, rem > 0);
    chk("busy_l", busy_l, rem > 0);
    chk("done_m", done_m, rem == 1 && !st);
    chk("done_l", done_l, rem == 1 && !st);
    if (!e_valid) begin
      chk("gate_m", out_m, 0);
      chk("gate_l", out_l, 0);
    end
    if (e_valid) rem--;
    xfer = v && e_ready;
    if (xfer) begin
      for (int i = 0; i < W; i++) begin
        q_m.push_back(d[W-1-i]);
        q_l.push_back(d[i]);
      end
      rem = W;
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    bit x = 0;
    for (int i = 0; i < 64 && !x; i++) cycle(1'b1, 1'b0, d, x);
    if (!x) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit x;
    repeat (n) cycle(1'b0, 1'b0, '0, x);
  endtask

  task automatic drain();
    bit x;
    for (int i = 0; i < 64 && rem > 0; i++) cycle(1'b0, 1'b0, '0, x);
    chk("drain_timeout", rem, 0);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (sv_m) begin
        if (q_m.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_m: got unexpected bit %0d expected none", out_m);
        end else chk("bit_m", out_m, q_m.pop_front());
      end
      if (sv_l) begin
        if (q_l.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_l: got unexpected bit %0d expected none", out_l);
        end else chk("bit_l", out_l, q_l.pop_front());
      end
    end
  end

  initial begin
    bit x;
    #1;
    chk("rst_ready", rdy_m, 0);
    chk("rst_valid", sv_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_l, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'hB4);
    drain();
    idle(2);
    send(8'hB6);
    send(8'hD0);
    drain();
    send(8'h2D);
    drain();
    send(8'hFF);
    idle(3);
    repeat (3) cycle(1'b0, 1'b1, '0, x);
    drain();
    send(8'hB6);
    idle(7);
    cycle(1'b1, 1'b1, 8'hD0, x);
    chk("stall_last_noxfer", x, 0);
    send(8'hD0);
    drain();
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, W'($urandom), x);
    drain();
    send(8'hA5);
    for (int i = 0; i < 16 && rem != 4; i++) cycle(1'b0, 1'b0, '0, x);
    @(negedge clk);
    s_valid = 1'b0;
    stall = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", sv_m, 0);
    chk("arst_out", out_m, 0);
    chk("arst_busy", busy_l, 0);
    chk("arst_ready", rdy_m, 0);
    q_m.delete();
    q_l.delete();
    rem = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h3C);
    drain();
    idle(2);
    chk("q_m_empty", q_m.size(), 0);
    chk("q_l_empty", q_l.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
